fft_stage_butterfly_seq: RTL and testbench

Sequential butterfly engine for one radix-2 FFT stage. It consumes one frame of SIZE_FFT complex fixed-point samples together with the SIZE_FFT/2 twiddles produced by the twiddle generator for the same STAGE_FFT. It computes all SIZE_FFT/2 butterflies through a single time-shared complex multiplier, one butterfly per cycle, and hands the stage result downstream over a val/rdy interface.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fixed_complex_mul.sv | 31 +++
 rtl/fft_stage_butterfly_seq.sv | 116 +++++++++++
 tb/tb_fft_stage_butterfly_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and index helpers for the radix-2 FFT stage engines.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Distance between the two legs of a butterfly in this stage.
  function automatic int bfly_half(input int stage);
    return 1 << stage;
  endfunction

  // Upper leg: group index scaled to a 2*half stride, plus offset inside the group.
  function automatic int bfly_p(input int b, input int stage);
    return ((b >> stage) << (stage + 1)) | (b & (bfly_half(stage) - 1));
  endfunction

  // Lower leg sits half positions above the upper one.
  function automatic int bfly_q(input int b, input int stage);
    return bfly_p(b, stage) + bfly_half(stage);
  endfunction

endpackage

// File: rtl/fixed_complex_mul.sv
// Combinational fixed-point complex multiply: products kept at full width,
// combined, floor-shifted by DECIMAL_PT and truncated back to BIT_WIDTH.
module fixed_complex_mul #(
  parameter int BIT_WIDTH  = 4,
  parameter int DECIMAL_PT = 2
) (
  input  logic signed [BIT_WIDTH-1:0] a_re,
  input  logic signed [BIT_WIDTH-1:0] a_im,
  input  logic signed [BIT_WIDTH-1:0] b_re,
  input  logic signed [BIT_WIDTH-1:0] b_im,
  output logic signed [BIT_WIDTH-1:0] p_re,
  output logic signed [BIT_WIDTH-1:0] p_im
);

  // One guard bit above 2*BIT_WIDTH so ad+bc cannot overflow before the shift.
  localparam int PW = 2 * BIT_WIDTH + 1;

  logic signed [PW-1:0] ac, bd, ad, bc, re_full, im_full;

  assign ac      = PW'(a_re) * PW'(b_re);
  assign bd      = PW'(a_im) * PW'(b_im);
  assign ad      = PW'(a_re) * PW'(b_im);
  assign bc      = PW'(a_im) * PW'(b_re);
  assign re_full = ac - bd;
  assign im_full = ad + bc;

  // Arithmetic shift floors toward -inf; the cast keeps the low BIT_WIDTH bits.
  assign p_re = BIT_WIDTH'(re_full >>> DECIMAL_PT);
  assign p_im = BIT_WIDTH'(im_full >>> DECIMAL_PT);

endmodule

// File: rtl/fft_stage_butterfly_seq.sv
// One radix-2 FFT stage: latches a frame plus its twiddles, runs one butterfly
// per cycle through a shared complex multiplier, then holds the result until
// downstream takes it.
module fft_stage_butterfly_seq
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = 4,
  parameter int DECIMAL_PT = 2,
  parameter int SIZE_FFT   = 8,
  parameter int STAGE_FFT  = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 recv_val,
  output logic                                 recv_rdy,
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]   in_real,
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]   in_imag,
  input  logic [SIZE_FFT/2-1:0][BIT_WIDTH-1:0] twiddle_real,
  input  logic [SIZE_FFT/2-1:0][BIT_WIDTH-1:0] twiddle_imaginary,
  output logic                                 send_val,
  input  logic                                 send_rdy,
  output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]   out_real,
  output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]   out_imag
);

  localparam int NB = SIZE_FFT / 2;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = $clog2(SIZE_FFT);

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last;

  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] x_re, x_im, y_re, y_im;
  logic [NB-1:0][BIT_WIDTH-1:0]       w_re, w_im;

  logic [IW-1:0]        p_idx, q_idx;
  logic [BIT_WIDTH-1:0] t_re, t_im;

  assign last  = (cnt == CW'(NB - 1));
  assign p_idx = IW'(bfly_p(int'(cnt), STAGE_FFT));
  assign q_idx = IW'(bfly_q(int'(cnt), STAGE_FFT));

  fixed_complex_mul #(
    .BIT_WIDTH (BIT_WIDTH),
    .DECIMAL_PT(DECIMAL_PT)
  ) u_cmul (
    .a_re(w_re[cnt]),
    .a_im(w_im[cnt]),
    .b_re(x_re[q_idx]),
    .b_im(x_im[q_idx]),
    .p_re(t_re),
    .p_im(t_im)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs, decoded from state only.
  always_comb begin
    state_nxt = state;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) state_nxt = COMP;
      end
      COMP: if (last) state_nxt = DONE;
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame capture, butterfly writeback and butterfly counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      x_re <= '0;
      x_im <= '0;
      y_re <= '0;
      y_im <= '0;
      w_re <= '0;
      w_im <= '0;
    end else begin
      case (state)
        IDLE: if (recv_val) begin
          x_re <= in_real;
          x_im <= in_imag;
          w_re <= twiddle_real;
          w_im <= twiddle_imaginary;
          cnt  <= '0;
        end
        COMP: begin
          // Inputs are read from x_* only, so writing y_* cannot disturb later butterflies.
          y_re[p_idx] <= x_re[p_idx] + t_re;
          y_im[p_idx] <= x_im[p_idx] + t_im;
          y_re[q_idx] <= x_re[p_idx] - t_re;
          y_im[q_idx] <= x_im[p_idx] - t_im;
          cnt         <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_real = y_re;
  assign out_imag = y_im;

endmodule

// File: tb/tb_fft_stage_butterfly_seq.sv
// Bench: two stage instances (stage 0 and stage 1, 4-point, Q4 8-bit) share stimulus
// and are checked against a plain-arithmetic DFT-stage model and hand vectors.
module tb_fft_stage_butterfly_seq;

  localparam int W = 8;
  localparam int N = 4;

  typedef logic [N-1:0][W-1:0]   frame_t;
  typedef logic [N/2-1:0][W-1:0] tw_t;

  typedef struct packed {
    logic   stg;
    frame_t ir, ii;
    tw_t    wr, wi;
    frame_t er, ei;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   recv_val = 1'b0;
  logic   send_rdy = 1'b1;
  frame_t in_real = '0, in_imag = '0;
  tw_t    tw_re = '0, tw_im = '0;
  logic   rr0, rr1, sv0, sv1;
  frame_t o0r, o0i, o1r, o1i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fft_stage_butterfly_seq #(.BIT_WIDTH(W), .DECIMAL_PT(4), .SIZE_FFT(N), .STAGE_FFT(0)) u_s0 (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rr0),
    .in_real(in_real), .in_imag(in_imag), .twiddle_real(tw_re), .twiddle_imaginary(tw_im),
    .send_val(sv0), .send_rdy(send_rdy), .out_real(o0r), .out_imag(o0i));

  fft_stage_butterfly_seq #(.BIT_WIDTH(W), .DECIMAL_PT(4), .SIZE_FFT(N), .STAGE_FFT(1)) u_s1 (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rr1),
    .in_real(in_real), .in_imag(in_imag), .twiddle_real(tw_re), .twiddle_imaginary(tw_im),
    .send_val(sv1), .send_rdy(send_rdy), .out_real(o1r), .out_imag(o1i));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'(signed'(v));
  endfunction

  // Reference: butterflies computed with integer arithmetic, floor division by 16, wrap to 8 bits.
  task automatic model(input int s, input frame_t xr, input frame_t xi, input tw_t wr, input tw_t wi,
                       output frame_t yr, output frame_t yi);
    int h, p, q, tr, ti;
    yr = '0;
    yi = '0;
    h  = 1 << s;
    for (int b = 0; b < N / 2; b++) begin
      p  = (b / h) * 2 * h + (b % h);
      q  = p + h;
      tr = (sx(wr[b]) * sx(xr[q]) - sx(wi[b]) * sx(xi[q])) >>> 4;
      ti = (sx(wr[b]) * sx(xi[q]) + sx(wi[b]) * sx(xr[q])) >>> 4;
      yr[p] = W'(sx(xr[p]) + tr);
      yi[p] = W'(sx(xi[p]) + ti);
      yr[q] = W'(sx(xr[p]) - tr);
      yi[q] = W'(sx(xi[p]) - ti);
    end
  endtask

  task automatic send_frame(input frame_t ir, input frame_t ii, input tw_t wr, input tw_t wi);
    int n;
    n = 0;
    while (!rr0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_rdy", 64'(rr0), 64'(1));
    in_real  = ir;
    in_imag  = ii;
    tw_re    = wr;
    tw_im    = wi;
    recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
  endtask

  // Counts the accept cycle as 1; returns with send_val seen or the bound expired.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!sv0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_models(input string tag);
    frame_t m0r, m0i, m1r, m1i;
    model(0, in_real, in_imag, tw_re, tw_im, m0r, m0i);
    model(1, in_real, in_imag, tw_re, tw_im, m1r, m1i);
    chk({tag, "_s0_re"}, 64'(o0r), 64'(m0r));
    chk({tag, "_s0_im"}, 64'(o0i), 64'(m0i));
    chk({tag, "_s1_re"}, 64'(o1r), 64'(m1r));
    chk({tag, "_s1_im"}, 64'(o1i), 64'(m1i));
    chk({tag, "_s1_val"}, 64'(sv1), 64'(1));
  endtask

  task automatic run_frame(input string tag, input frame_t ir, input frame_t ii, input tw_t wr, input tw_t wi);
    int lat;
    send_frame(ir, ii, wr, wi);
    wait_out(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(3));
    check_models(tag);
    @(posedge clk); #1;
    chk({tag, "_back_idle_rdy"}, 64'(rr0), 64'(1));
    chk({tag, "_back_idle_val"}, 64'(sv0), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t   vt[4];
    frame_t held_r, held_i, fr, fi;
    tw_t    wr, wi;
    int     lat;

    // Hand vectors: stg selects the instance whose outputs the expected values describe.
    vt[0] = '0; vt[0].stg = 1'b0;
    vt[0].ir = {8'(64), 8'(48), 8'(32), 8'(16)};
    vt[0].wr = {8'(16), 8'(16)};
    vt[0].er = {8'(-16), 8'(112), 8'(-16), 8'(48)};

    vt[1] = '0; vt[1].stg = 1'b1;
    vt[1].ir = {8'(16), 8'(0), 8'(0), 8'(16)};
    vt[1].wr = {8'(0), 8'(16)};
    vt[1].wi = {8'(-16), 8'(0)};
    vt[1].er = {8'(0), 8'(16), 8'(0), 8'(16)};
    vt[1].ei = {8'(16), 8'(0), 8'(-16), 8'(0)};

    vt[2] = '0; vt[2].stg = 1'b0;
    vt[2].ir = {8'(0), 8'(0), 8'(-3), 8'(0)};
    vt[2].wr = {8'(8), 8'(8)};
    vt[2].er = {8'(0), 8'(0), 8'(2), 8'(-2)};

    vt[3] = '0; vt[3].stg = 1'b0;
    vt[3].ir = {8'(0), 8'(0), 8'(64), 8'(64)};
    vt[3].wr = {8'(16), 8'(16)};
    vt[3].er = {8'(0), 8'(0), 8'(0), 8'(-128)};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_recv_rdy", 64'(rr0), 64'(1));
    chk("rst_send_val", 64'(sv0), 64'(0));
    chk("rst_out_re", 64'(o0r), 64'(0));
    chk("rst_out_im", 64'(o0i), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 4; i++) begin
      send_frame(vt[i].ir, vt[i].ii, vt[i].wr, vt[i].wi);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
      chk($sformatf("vec%0d_hand_re", i), 64'(vt[i].stg ? o1r : o0r), 64'(vt[i].er));
      chk($sformatf("vec%0d_hand_im", i), 64'(vt[i].stg ? o1i : o0i), 64'(vt[i].ei));
      check_models($sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle_rdy", i), 64'(rr0), 64'(1));
    end

    // Backpressure: DONE holds for 5 cycles, a recv_val pulse is ignored.
    send_rdy = 1'b0;
    send_frame(frame_t'($urandom), frame_t'($urandom), tw_t'($urandom), tw_t'($urandom));
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'(3));
    check_models("bp");
    held_r = o0r;
    held_i = o0i;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        recv_val = 1'b1;
        in_real  = ~in_real;
      end
      @(posedge clk); #1;
      recv_val = 1'b0;
      chk($sformatf("bp%0d_hold_re", k), 64'(o0r), 64'(held_r));
      chk($sformatf("bp%0d_hold_im", k), 64'(o0i), 64'(held_i));
      chk($sformatf("bp%0d_val", k), 64'(sv0), 64'(1));
      chk($sformatf("bp%0d_rdy", k), 64'(rr0), 64'(0));
    end
    send_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_rdy", 64'(rr0), 64'(1));
    chk("bp_release_val", 64'(sv0), 64'(0));

    // Reset asserted in the middle of COMP.
    send_frame(frame_t'($urandom), frame_t'($urandom), tw_t'($urandom), tw_t'($urandom));
    reset = 1'b0;
    #1;
    chk("midrst_rdy", 64'(rr0), 64'(1));
    chk("midrst_val", 64'(sv0), 64'(0));
    chk("midrst_out_re", 64'(o0r), 64'(0));
    chk("midrst_out_im", 64'(o1i), 64'(0));
    @(posedge clk); #1;
    chk("midrst_next_rdy", 64'(rr0), 64'(1));
    chk("midrst_next_val", 64'(sv0), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    run_frame("post_rst", frame_t'($urandom), frame_t'($urandom), tw_t'($urandom), tw_t'($urandom));

    // Randomized frames, some with a short downstream stall.
    for (int r = 0; r < 16; r++) begin
      fr = frame_t'($urandom);
      fi = frame_t'($urandom);
      wr = tw_t'($urandom);
      wi = tw_t'($urandom);
      if (r % 3 == 0) begin
        send_rdy = 1'b0;
        send_frame(fr, fi, wr, wi);
        wait_out(lat);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check_models($sformatf("rnd%0d", r));
        send_rdy = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("rnd%0d_rdy", r), 64'(rr0), 64'(1));
      end else begin
        run_frame($sformatf("rnd%0d", r), fr, fi, wr, wi);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
